// File: rtl/spi_cmd_sequencer.sv
// SPI command sequencer: decodes a command byte then burst-writes data bytes
// into a small register bank, reporting good/bad frame completion.
module spi_cmd_sequencer #(
  parameter int ADDR_W    = 2,
  parameter int MAX_BURST = 4
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  input  logic                      rx_err,
  input  logic                      cs_n,
  output logic [8*(2**ADDR_W)-1:0]  cfg_regs,
  output logic                      wr_stb,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic                      frame_done,
  output logic                      frame_err,
  output logic                      busy
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DROP} state_t;

  state_t            state;
  state_t            proc_state;
  state_t            nxt_state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] nxt_addr;
  logic [7:0]        count;
  logic [7:0]        nxt_count;
  logic              err_flag;
  logic              nxt_err;
  logic              do_write;
  logic              frame_end;
  logic              cmd_ok;

  // A write command has bit 7 set and no bits above the address field.
  assign cmd_ok = rx_data[7] && ((rx_data[6:0] >> ADDR_W) == 7'd0);

  // The received byte/error is applied first; a frame end seen in the same
  // cycle then judges the frame on that updated state.
  always_comb begin
    proc_state = state;
    nxt_addr   = addr;
    nxt_count  = count;
    nxt_err    = err_flag;
    do_write   = 1'b0;
    case (state)
      IDLE: begin
        if (!cs_n) begin
          proc_state = CMD;
          nxt_err    = 1'b0;
        end
      end
      CMD: begin
        if (rx_err) begin
          proc_state = DROP;
          nxt_err    = 1'b1;
        end else if (rx_valid) begin
          if (cmd_ok) begin
            proc_state = DATA;
            nxt_addr   = rx_data[ADDR_W-1:0];
            nxt_count  = 8'd0;
          end else begin
            proc_state = DROP;
            nxt_err    = 1'b1;
          end
        end
      end
      DATA: begin
        if (rx_err) begin
          proc_state = DROP;
          nxt_err    = 1'b1;
        end else if (rx_valid) begin
          if (count < 8'(MAX_BURST)) begin
            do_write  = 1'b1;
            nxt_addr  = addr + ADDR_W'(1);
            nxt_count = count + 8'd1;
          end else begin
            proc_state = DROP;
            nxt_err    = 1'b1;
          end
        end
      end
      default: ;
    endcase
    frame_end = (state != IDLE) && cs_n;
    nxt_state = frame_end ? IDLE : proc_state;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      addr       <= '0;
      count      <= 8'd0;
      err_flag   <= 1'b0;
      cfg_regs   <= '0;
      wr_stb     <= 1'b0;
      wr_addr    <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= nxt_state;
      addr       <= nxt_addr;
      count      <= nxt_count;
      err_flag   <= nxt_err;
      wr_stb     <= do_write;
      if (do_write) begin
        cfg_regs[int'(addr)*8 +: 8] <= rx_data;
        wr_addr                     <= addr;
      end
      frame_err  <= frame_end && nxt_err;
      frame_done <= frame_end && !nxt_err && (proc_state == DATA) && (nxt_count != 8'd0);
      busy       <= (nxt_state != IDLE);
    end
  end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed bench for spi_cmd_sequencer: expected writes and frame outcomes
// are queued as bytes are driven and consumed when the DUT reports them.
module tb_spi_cmd_sequencer;

  localparam int ADDR_W    = 2;
  localparam int MAX_BURST = 4;
  localparam int NREG      = 2**ADDR_W;
  localparam logic [1:0] EV_DONE = 2'b01;
  localparam logic [1:0] EV_ERR  = 2'b10;

  logic                 sys_clk;
  logic                 sys_rst_n;
  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic                 rx_err;
  logic                 cs_n;
  logic [8*NREG-1:0]    cfg_regs;
  logic                 wr_stb;
  logic [ADDR_W-1:0]    wr_addr;
  logic                 frame_done;
  logic                 frame_err;
  logic                 busy;

  int checks;
  int errors;
  logic [7:0]        model_regs [NREG];
  logic [ADDR_W+7:0] exp_wr [$];
  logic [1:0]        exp_ev [$];

  spi_cmd_sequencer #(.ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_err(rx_err), .cs_n(cs_n), .cfg_regs(cfg_regs),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .frame_done(frame_done),
    .frame_err(frame_err), .busy(busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic expectWrite(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    exp_wr.push_back({a, d});
    model_regs[a] = d;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic startFrame();
    cs_n = 1'b0;
    tick();
    checkOutput("busy_in_frame", busy, 1);
  endtask

  task automatic endFrame(input string tag);
    cs_n = 1'b1;
    repeat (3) tick();
    checkOutput({tag, "_busy_idle"}, busy, 0);
    checkOutput({tag, "_writes_left"}, exp_wr.size(), 0);
    checkOutput({tag, "_events_left"}, exp_ev.size(), 0);
    exp_wr.delete();
    exp_ev.delete();
  endtask

  task automatic checkRegs(input string tag);
    for (int i = 0; i < NREG; i++)
      checkOutput(tag, cfg_regs[i*8 +: 8], model_regs[i]);
  endtask

  // Monitor: every write and frame pulse must match the next queued expectation.
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (wr_stb) begin
        checkOutput("wr_expected", wr_stb, exp_wr.size() != 0);
        if (exp_wr.size() != 0) begin
          logic [ADDR_W+7:0] e;
          e = exp_wr.pop_front();
          checkOutput("wr_addr", wr_addr, e[ADDR_W+7:8]);
          checkOutput("wr_data", cfg_regs[int'(wr_addr)*8 +: 8], e[7:0]);
        end
      end
      if (frame_done || frame_err) begin
        checkOutput("frame_ev_expected", 1, exp_ev.size() != 0);
        if (exp_ev.size() != 0)
          checkOutput("frame_ev_kind", {frame_err, frame_done}, exp_ev.pop_front());
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < NREG; i++) model_regs[i] = 8'h00;
    sys_rst_n = 1'b0;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    rx_err    = 1'b0;
    cs_n      = 1'b1;
    repeat (2) tick();
    checkRegs("reset_regs");
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_pulses", {wr_stb, frame_done, frame_err}, 0);
    sys_rst_n = 1'b1;
    repeat (2) tick();
    checkOutput("idle_busy", busy, 0);

    $display("[TB] write burst");
    startFrame();
    applyStimulus(8'h81);
    expectWrite(2'd1, 8'hAA); applyStimulus(8'hAA);
    expectWrite(2'd2, 8'hBB); applyStimulus(8'hBB);
    exp_ev.push_back(EV_DONE);
    endFrame("burst");
    checkRegs("burst_regs");

    $display("[TB] address wrap");
    startFrame();
    applyStimulus(8'h83);
    expectWrite(2'd3, 8'h11); applyStimulus(8'h11);
    expectWrite(2'd0, 8'h22); applyStimulus(8'h22);
    exp_ev.push_back(EV_DONE);
    endFrame("wrap");
    checkRegs("wrap_regs");

    $display("[TB] overflow");
    startFrame();
    applyStimulus(8'h80);
    for (int i = 0; i < MAX_BURST + 1; i++) begin
      if (i < MAX_BURST) expectWrite(ADDR_W'(i), 8'(i + 1));
      applyStimulus(8'(i + 1));
    end
    exp_ev.push_back(EV_ERR);
    endFrame("overflow");
    checkRegs("overflow_regs");

    $display("[TB] bad opcodes");
    startFrame();
    applyStimulus(8'h40);
    applyStimulus(8'h55);
    exp_ev.push_back(EV_ERR);
    endFrame("bad_op40");
    startFrame();
    applyStimulus(8'h84);
    applyStimulus(8'h55);
    exp_ev.push_back(EV_ERR);
    endFrame("bad_op84");
    checkRegs("bad_op_regs");

    $display("[TB] rx_err during data");
    startFrame();
    applyStimulus(8'h80);
    expectWrite(2'd0, 8'h66); applyStimulus(8'h66);
    rx_err = 1'b1; tick(); rx_err = 1'b0;
    applyStimulus(8'h77);
    exp_ev.push_back(EV_ERR);
    endFrame("rx_err");
    checkRegs("rx_err_regs");

    $display("[TB] last byte with frame end");
    startFrame();
    applyStimulus(8'h82);
    expectWrite(2'd2, 8'h99);
    exp_ev.push_back(EV_DONE);
    rx_data = 8'h99; rx_valid = 1'b1; cs_n = 1'b1;
    tick();
    rx_valid = 1'b0;
    @(negedge sys_clk);
    checkOutput("coincide_pulses", {wr_stb, frame_done, frame_err}, 3'b110);
    endFrame("coincide");
    checkRegs("coincide_regs");

    $display("[TB] empty and command-only frames");
    startFrame();
    tick();
    endFrame("empty");
    startFrame();
    applyStimulus(8'h81);
    endFrame("cmd_only");
    checkRegs("empty_regs");

    $display("[TB] reset mid-burst");
    startFrame();
    applyStimulus(8'h81);
    expectWrite(2'd1, 8'h5A); applyStimulus(8'h5A);
    @(negedge sys_clk);
    #1;
    checkOutput("pre_reset_reg1", cfg_regs[15:8], 8'h5A);
    rx_data = 8'h5B; rx_valid = 1'b1;
    sys_rst_n = 1'b0;
    #1;
    for (int i = 0; i < NREG; i++) model_regs[i] = 8'h00;
    checkRegs("async_reset_regs");
    checkOutput("async_reset_busy", busy, 0);
    checkOutput("async_reset_pulses", {wr_stb, frame_done, frame_err}, 0);
    rx_valid = 1'b0;
    cs_n = 1'b1;
    tick();
    sys_rst_n = 1'b1;
    repeat (3) tick();
    checkOutput("post_reset_busy", busy, 0);
    checkOutput("post_reset_writes_left", exp_wr.size(), 0);
    startFrame();
    applyStimulus(8'h83);
    expectWrite(2'd3, 8'h3C); applyStimulus(8'h3C);
    exp_ev.push_back(EV_DONE);
    endFrame("post_reset");
    checkRegs("post_reset_regs");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
